// File: rtl/alu_unit.sv
// Execution unit: single-cycle ALU/branch/jump evaluation plus a bit-serial shifter.
// One operation in flight; the result is held on the broadcast bus until granted.
module alu_unit #(
  parameter int unsigned RobBits = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [31:0]        in_vj,
  input  logic [31:0]        in_vk,
  input  logic [31:0]        in_imm,
  input  logic [5:0]         in_op,
  input  logic [31:0]        in_pc,
  input  logic               in_jalr,
  input  logic [RobBits-1:0] in_rob_id,
  output logic               in_ready,
  output logic               out_valid,
  output logic [31:0]        out_value,
  output logic [RobBits-1:0] out_rob_id,
  output logic               out_jump,
  output logic [31:0]        out_target,
  input  logic               out_grant,
  output logic               finish_rdy
);

  typedef enum logic [1:0] {StIdle, StShift, StOut} state_e;

  localparam logic [1:0] TypeU = 2'd0;
  localparam logic [1:0] TypeI = 2'd1;
  localparam logic [1:0] TypeB = 2'd2;
  localparam logic [1:0] TypeR = 2'd3;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [31:0]         val_q, val_d;
  logic [RobBits-1:0]  rob_q, rob_d;
  logic                jump_q, jump_d;
  logic [31:0]         target_q, target_d;
  logic                left_q, left_d;
  logic                arith_q, arith_d;

  logic [1:0]  op_type;
  logic [2:0]  funct3;
  logic        funct7;
  logic        is_jal, is_sub, f7_bad, is_alu, is_shift;
  logic [31:0] op_b, alu_res, pc_imm, pc_4, jalr_sum;
  logic [4:0]  shamt;
  logic        br_taken;

  assign op_type  = in_op[1:0];
  assign funct3   = in_op[4:2];
  assign funct7   = in_op[5];
  assign is_jal   = (in_op == 6'b111111);
  assign op_b     = (op_type == TypeI) ? in_imm : in_vk;
  assign shamt    = op_b[4:0];
  assign is_alu   = (op_type == TypeI) || (op_type == TypeR);
  assign is_sub   = (op_type == TypeR) && funct7 && (funct3 == 3'b000);
  // funct7 only qualifies SUB and SRA/SRAI; any other R-type use falls back to ADD
  assign f7_bad   = (op_type == TypeR) && funct7 && (funct3 != 3'b000) && (funct3 != 3'b101);
  assign is_shift = is_alu && !in_jalr && !is_jal && !f7_bad &&
                    ((funct3 == 3'b001) || (funct3 == 3'b101));
  assign pc_imm   = in_pc + in_imm;
  assign pc_4     = in_pc + 32'd4;
  assign jalr_sum = in_vj + in_imm;

  always_comb begin
    alu_res = in_vj + op_b;
    if (!f7_bad) begin
      case (funct3)
        3'b000:         alu_res = is_sub ? (in_vj - op_b) : (in_vj + op_b);
        // Shifts by zero never enter the shifter, so pass the operand through
        3'b001, 3'b101: alu_res = in_vj;
        3'b010:         alu_res = {31'b0, ($signed(in_vj) < $signed(op_b))};
        3'b011:         alu_res = {31'b0, (in_vj < op_b)};
        3'b100:         alu_res = in_vj ^ op_b;
        3'b110:         alu_res = in_vj | op_b;
        default:        alu_res = in_vj & op_b;
      endcase
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (in_vj == in_vk);
      3'b001:  br_taken = (in_vj != in_vk);
      3'b100:  br_taken = ($signed(in_vj) < $signed(in_vk));
      3'b101:  br_taken = ($signed(in_vj) >= $signed(in_vk));
      3'b110:  br_taken = (in_vj < in_vk);
      3'b111:  br_taken = (in_vj >= in_vk);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    rob_d    = rob_q;
    jump_d   = jump_q;
    target_d = target_q;
    left_d   = left_q;
    arith_d  = arith_q;
    if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            rob_d    = in_rob_id;
            jump_d   = 1'b0;
            target_d = 32'd0;
            cnt_d    = 5'd0;
            if (in_jalr) begin
              val_d    = pc_4;
              jump_d   = 1'b1;
              target_d = {jalr_sum[31:1], 1'b0};
            end else if (is_jal) begin
              val_d    = pc_4;
              jump_d   = 1'b1;
              target_d = pc_imm;
            end else if (op_type == TypeU) begin
              val_d = in_imm;
            end else if (op_type == TypeB) begin
              val_d    = 32'd0;
              jump_d   = br_taken;
              target_d = pc_imm;
            end else begin
              val_d = alu_res;
            end
            if (is_shift && (shamt != 5'd0)) begin
              state_d = StShift;
              cnt_d   = shamt;
              val_d   = in_vj;
              left_d  = (funct3 == 3'b001);
              arith_d = funct7;
            end else begin
              state_d = StOut;
            end
          end
        end
        StShift: begin
          if (left_q) begin
            val_d = {val_q[30:0], 1'b0};
          end else begin
            val_d = {(arith_q & val_q[31]), val_q[31:1]};
          end
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = StOut;
          end
        end
        StOut: begin
          if (out_grant) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      val_q    <= 32'd0;
      rob_q    <= '0;
      jump_q   <= 1'b0;
      target_q <= 32'd0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      rob_q    <= rob_d;
      jump_q   <= jump_d;
      target_q <= target_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StOut);
  assign out_value  = val_q;
  assign out_rob_id = rob_q;
  assign out_jump   = jump_q;
  assign out_target = target_q;
  assign finish_rdy = out_valid & out_grant & ~clear;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: stimulus pushes expected results, a monitor checks them on grant.
module tb_alu_unit;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, in_valid, in_jalr, out_grant;
  logic [31:0] in_vj, in_vk, in_imm, in_pc;
  logic [5:0]  in_op;
  logic [3:0]  in_rob_id;
  logic        in_ready, out_valid, out_jump, finish_rdy;
  logic [31:0] out_value, out_target;
  logic [3:0]  out_rob_id;

  typedef struct {
    logic [31:0] val;
    logic [3:0]  rob;
    logic        jump;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  alu_unit #(.RobBits(4)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_vj      (in_vj),
    .in_vk      (in_vk),
    .in_imm     (in_imm),
    .in_op      (in_op),
    .in_pc      (in_pc),
    .in_jalr    (in_jalr),
    .in_rob_id  (in_rob_id),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_value  (out_value),
    .out_rob_id (out_rob_id),
    .out_jump   (out_jump),
    .out_target (out_target),
    .out_grant  (out_grant),
    .finish_rdy (finish_rdy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (out_valid && out_grant && !clear) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected result: got value %h with empty scoreboard", out_value);
      end else begin
        mon_e = sb.pop_front();
        chk("mon value",  out_value,  mon_e.val);
        chk("mon rob",    {28'b0, out_rob_id}, {28'b0, mon_e.rob});
        chk("mon jump",   {31'b0, out_jump},   {31'b0, mon_e.jump});
        chk("mon target", out_target, mon_e.target);
        chk("mon finish", {31'b0, finish_rdy}, 32'd1);
      end
    end
  end

  task automatic drive(input logic [31:0] vj, vk, imm, input logic [5:0] op,
                       input logic [31:0] pc, input logic jalr, input logic [3:0] rob);
    in_vj = vj; in_vk = vk; in_imm = imm; in_op = op; in_pc = pc;
    in_jalr = jalr; in_rob_id = rob; in_valid = 1'b1;
  endtask

  task automatic run_op(input string name, input logic [31:0] vj, vk, imm,
                        input logic [5:0] op, input logic [31:0] pc, input logic jalr,
                        input logic [3:0] rob, input logic [31:0] e_val, input logic e_jump,
                        input logic [31:0] e_tgt, input int e_lat, input int freeze,
                        input int hold);
    exp_t e;
    int   lat;
    bit   seen;
    chk({name, " ready"}, {31'b0, in_ready}, 32'd1);
    drive(vj, vk, imm, op, pc, jalr, rob);
    e.val = e_val; e.rob = rob; e.jump = e_jump; e.target = e_tgt;
    sb.push_back(e);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk_in); #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        chk({name, " busy"}, {31'b0, in_ready}, 32'd0);
        rdy_in = (lat <= freeze) ? 1'b0 : 1'b1;
      end
    end
    rdy_in = 1'b1;
    chk({name, " latency"}, lat, e_lat);
    for (int h = 0; h < hold; h++) begin
      drive(32'd99, 32'd1, 32'd0, 6'b000011, 32'd0, 1'b0, 4'd9);
      @(posedge clk_in); #1;
      chk({name, " hold value"},  out_value, e_val);
      chk({name, " hold target"}, out_target, e_tgt);
      chk({name, " hold valid"},  {31'b0, out_valid}, 32'd1);
      chk({name, " hold finish"}, {31'b0, finish_rdy}, 32'd0);
      chk({name, " hold ready"},  {31'b0, in_ready}, 32'd0);
    end
    out_grant = 1'b1;
    @(posedge clk_in); #1;
    out_grant = 1'b0;
    in_valid  = 1'b0;
    chk({name, " released"}, {31'b0, out_valid}, 32'd0);
    chk({name, " idle"},     {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int highs;
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; out_grant = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 6'd0, 32'd0, 1'b0, 4'd0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    chk("reset valid", {31'b0, out_valid}, 32'd0);
    chk("reset ready", {31'b0, in_ready}, 32'd1);
    chk("reset value", out_value, 32'd0);

    //     name    vj            vk            imm           op         pc         jalr rob val           jmp target      lat frz hold
    run_op("add",  32'd5,        32'd7,        32'd0,        6'b000011, 32'h0,     0, 3, 32'd12,       0, 32'h0,       1,  0, 3);
    run_op("srai", 32'h80000000, 32'd0,        32'd4,        6'b110101, 32'h0,     0, 1, 32'hF8000000, 0, 32'h0,       5,  0, 0);
    run_op("bltu", 32'd1,        32'hFFFFFFFF, 32'h20,       6'b011010, 32'h100,   0, 2, 32'd0,        1, 32'h120,     1,  0, 0);
    run_op("blt",  32'd1,        32'hFFFFFFFF, 32'h20,       6'b010010, 32'h100,   0, 4, 32'd0,        0, 32'h120,     1,  0, 0);
    run_op("jalr", 32'h1003,     32'd0,        32'd2,        6'b000001, 32'h40,    1, 5, 32'h44,       1, 32'h1004,    1,  0, 0);
    run_op("jal",  32'd0,        32'd0,        32'h10,       6'b111111, 32'h200,   0, 6, 32'h204,      1, 32'h210,     1,  0, 0);
    run_op("sub",  32'd3,        32'd5,        32'd0,        6'b100011, 32'h0,     0, 7, 32'hFFFFFFFE, 0, 32'h0,       1,  0, 0);
    run_op("slt",  32'hFFFFFFFF, 32'd1,        32'd0,        6'b001011, 32'h0,     0, 8, 32'd1,        0, 32'h0,       1,  0, 0);
    run_op("sltu", 32'hFFFFFFFF, 32'd1,        32'd0,        6'b001111, 32'h0,     0, 8, 32'd0,        0, 32'h0,       1,  0, 0);
    run_op("lui",  32'd0,        32'd0,        32'hABCDE000, 6'b000000, 32'h0,     0, 9, 32'hABCDE000, 0, 32'h0,       1,  0, 0);
    run_op("undef",32'd2,        32'd3,        32'd0,        6'b110011, 32'h0,     0, 10,32'd5,        0, 32'h0,       1,  0, 0);
    run_op("sll0", 32'h1234,     32'd0,        32'd0,        6'b000111, 32'h0,     0, 11,32'h1234,     0, 32'h0,       1,  0, 0);
    run_op("srl8", 32'h80000000, 32'd8,        32'd0,        6'b010111, 32'h0,     0, 12,32'h00800000, 0, 32'h0,       9,  0, 0);
    run_op("xori", 32'hF0F0,     32'd0,        32'h0FF0,     6'b010001, 32'h0,     0, 13,32'hFF00,     0, 32'h0,       1,  0, 0);
    run_op("and",  32'hFF00FF00, 32'h0F0F0F0F, 32'd0,        6'b011111, 32'h0,     0, 14,32'h0F000F00, 0, 32'h0,       1,  0, 0);
    run_op("beq",  32'd7,        32'd7,        32'hFFFFFFF0, 6'b000010, 32'h0,     0, 15,32'd0,        1, 32'hFFFFFFF0,1,  0, 0);
    run_op("wrap", 32'hFFFFFFFF, 32'd2,        32'd0,        6'b000011, 32'h0,     0, 1, 32'd1,        0, 32'h0,       1,  0, 0);
    run_op("slli", 32'd1,        32'd0,        32'd3,        6'b000101, 32'h0,     0, 2, 32'd8,        0, 32'h0,       4,  0, 0);
    run_op("frz",  32'd1,        32'd0,        32'd3,        6'b000101, 32'h0,     0, 3, 32'd8,        0, 32'h0,       8,  4, 0);

    // Flush a long shift mid-flight: nothing may be broadcast afterwards.
    drive(32'd1, 32'd20, 32'd0, 6'b000111, 32'h0, 1'b0, 4'd4);
    @(posedge clk_in); #1 in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk_in); #1;
      chk("clear pre valid", {31'b0, out_valid}, 32'd0);
    end
    clear = 1'b1;
    @(posedge clk_in); #1 clear = 1'b0;
    chk("clear idle",  {31'b0, in_ready}, 32'd1);
    chk("clear valid", {31'b0, out_valid}, 32'd0);
    highs = 0;
    out_grant = 1'b1;
    repeat (30) begin
      @(posedge clk_in); #1;
      if (out_valid || finish_rdy) highs++;
    end
    out_grant = 1'b0;
    chk("clear quiet", highs, 32'd0);

    // Reset while a result is waiting for the bus wipes the outputs.
    drive(32'd5, 32'd7, 32'd0, 6'b000011, 32'h0, 1'b0, 4'd3);
    @(posedge clk_in); #1 in_valid = 1'b0;
    chk("rst pre valid", {31'b0, out_valid}, 32'd1);
    rst_in = 1'b1;
    @(posedge clk_in); #1 rst_in = 1'b0;
    chk("rst valid", {31'b0, out_valid}, 32'd0);
    chk("rst value", out_value, 32'd0);
    chk("rst rob",   {28'b0, out_rob_id}, 32'd0);
    chk("rst ready", {31'b0, in_ready}, 32'd1);

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
